// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared play-state enum and screen/score constants
//
// Purpose : common types and constants for the frogger game-rule logic.
// Contents: state_t (IDLE/PLAY/HIT/GAME_OVER), screen size, goal row, score width.
package frogger_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    HIT       = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int c_SCREEN_W = 640;
  localparam int c_SCREEN_H = 480;
  localparam int c_GOAL_Y   = 32;
  localparam int c_SCORE_W  = 7;

endpackage

// File: rtl/frame_hit_latch.sv
// rtl/frame_hit_latch.sv - per-frame frog/car overlap flag with frame handover
//
// Purpose : remembers whether any overlap happened during the current frame.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           hit_term        - frog flag AND any car flag, this pixel
//           frame_start     - first pixel of a new frame
//           enable          - high while the game is being played
//           prev_hit        - flag value; on a frame-start cycle this is the
//                             result for the frame that just finished
module frame_hit_latch (
  input  logic clk,
  input  logic rst,
  input  logic hit_term,
  input  logic frame_start,
  input  logic enable,
  output logic prev_hit
);

  logic flag;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      flag <= 1'b0;
    end else if (frame_start) begin
      // The frame-start pixel already belongs to the new frame.
      flag <= hit_term;
    end else if (hit_term) begin
      flag <= 1'b1;
    end
  end

  assign prev_hit = flag;

endmodule

// File: rtl/collision_ctrl.sv
// rtl/collision_ctrl.sv - frogger play state machine, lives and score
//
// Purpose : detects frog/car overlap per frame, runs IDLE/PLAY/HIT/GAME_OVER,
//           keeps lives and score, and issues frog respawn pulses.
// Ports   : i_Clk, i_Rst     - pixel clock, synchronous active-high reset
//           i_Start          - start pulse
//           i_Frame_Start    - first pixel of each frame
//           i_Draw_Frog      - frog pixel flag
//           i_Draw_Cars      - per-car pixel flags
//           i_Frog_Y         - frog row
//           o_Game_Active    - high in PLAY (cars move)
//           o_Frog_Reset     - one-cycle respawn pulse
//           o_Lives, o_Score - remaining lives, goals reached
//           o_Game_Over      - high in GAME_OVER
module collision_ctrl #(
  parameter int c_NUM_CARS   = 4,
  parameter int c_LIVES      = 3,
  parameter int c_HIT_FRAMES = 60,
  parameter int c_GOAL_Y     = frogger_pkg::c_GOAL_Y,
  parameter int c_SCORE_MAX  = 99
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic                          i_Start,
  input  logic                          i_Frame_Start,
  input  logic                          i_Draw_Frog,
  input  logic [c_NUM_CARS-1:0]         i_Draw_Cars,
  input  logic [9:0]                    i_Frog_Y,
  output logic                          o_Game_Active,
  output logic                          o_Frog_Reset,
  output logic [1:0]                    o_Lives,
  output logic [frogger_pkg::c_SCORE_W-1:0] o_Score,
  output logic                          o_Game_Over
);

  import frogger_pkg::*;

  localparam int CNT_W = $clog2(c_HIT_FRAMES);
  localparam logic [CNT_W-1:0]     c_CNT_LAST  = CNT_W'(c_HIT_FRAMES - 1);
  localparam logic [1:0]           c_LIVES_LD  = 2'(c_LIVES);
  localparam logic [c_SCORE_W-1:0] c_SCORE_TOP = c_SCORE_W'(c_SCORE_MAX);
  localparam logic [9:0]           c_GOAL_ROW  = 10'(c_GOAL_Y);

  state_t               state, next_state;
  logic [CNT_W-1:0]     frame_cnt, frame_cnt_nxt;
  logic [1:0]           lives_nxt;
  logic [c_SCORE_W-1:0] score_nxt;
  logic                 frog_reset_nxt;
  logic                 collision;
  logic                 prev_hit;

  assign collision = i_Draw_Frog & (|i_Draw_Cars);

  frame_hit_latch u_hit_latch (
    .clk         (i_Clk),
    .rst         (i_Rst),
    .hit_term    (collision),
    .frame_start (i_Frame_Start),
    .enable      (state == PLAY),
    .prev_hit    (prev_hit)
  );

  // State register; all outputs are registered alongside it.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state         <= IDLE;
      frame_cnt     <= '0;
      o_Lives       <= '0;
      o_Score       <= '0;
      o_Frog_Reset  <= 1'b0;
      o_Game_Active <= 1'b0;
      o_Game_Over   <= 1'b0;
    end else begin
      state         <= next_state;
      frame_cnt     <= frame_cnt_nxt;
      o_Lives       <= lives_nxt;
      o_Score       <= score_nxt;
      o_Frog_Reset  <= frog_reset_nxt;
      o_Game_Active <= (next_state == PLAY);
      o_Game_Over   <= (next_state == GAME_OVER);
    end
  end

  // Next-state logic. A start in IDLE/GAME_OVER wins over a coincident frame start.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, GAME_OVER: begin
        if (i_Start) next_state = PLAY;
      end
      PLAY: begin
        if (i_Frame_Start && prev_hit)
          next_state = (o_Lives > 2'd1) ? HIT : GAME_OVER;
      end
      HIT: begin
        if (i_Frame_Start && (frame_cnt == c_CNT_LAST)) next_state = PLAY;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output/datapath logic.
  always_comb begin
    lives_nxt      = o_Lives;
    score_nxt      = o_Score;
    frame_cnt_nxt  = frame_cnt;
    frog_reset_nxt = 1'b0;
    case (state)
      IDLE, GAME_OVER: begin
        if (i_Start) begin
          lives_nxt      = c_LIVES_LD;
          score_nxt      = '0;
          frog_reset_nxt = 1'b1;
        end
      end
      PLAY: begin
        if (i_Frame_Start) begin
          if (prev_hit) begin
            // Hit beats goal in the same frame.
            if (o_Lives > 2'd1) begin
              lives_nxt     = o_Lives - 2'd1;
              frame_cnt_nxt = '0;
            end else begin
              lives_nxt = 2'd0;
            end
          end else if (i_Frog_Y <= c_GOAL_ROW) begin
            if (o_Score < c_SCORE_TOP) score_nxt = o_Score + 1'b1;
            // Keeps the respawn pulse from ever stretching over two cycles.
            frog_reset_nxt = ~o_Frog_Reset;
          end
        end
      end
      HIT: begin
        if (i_Frame_Start) begin
          if (frame_cnt == c_CNT_LAST) frog_reset_nxt = 1'b1;
          else                         frame_cnt_nxt  = frame_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
